// File: rtl/master_in_port.sv
// Bit-serial LSB-first receive stage: handshakes a frame, checks framing, presents words to the core.
// Optional output FIFO enabled by defining MASTER_IN_FIFO_EN (default: single holding register).
module master_in_port #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx_req,
   input  logic                  slave_ready,
   input  logic                  slave_valid,
   input  logic                  rx_bit,
   input  logic                  slave_tx_done,
   output logic                  master_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ack,
   output logic                  rx_busy,
   output logic                  frame_err
);

   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
   localparam int IDX_W = $clog2(DATA_WIDTH);

   typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  master_ready_q, master_ready_d;
   logic                  rx_busy_q, rx_busy_d;
   logic                  frame_err_q, frame_err_d;
   logic                  last_bit;
   logic                  push;
   logic                  pop;
   logic                  space_d;

   assign push = (state_q == DONE);
   assign pop  = rx_valid & rx_ack;

   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      frame_err_d = 1'b0;
      last_bit    = (bit_cnt_q == CNT_W'(DATA_WIDTH - 1));
      case (state_q)
         IDLE: begin
            if (master_ready_q && slave_ready) begin
               state_d   = RECV;
               bit_cnt_d = '0;
            end
         end
         RECV: begin
            shift_d[bit_cnt_q[IDX_W-1:0]] = rx_bit;
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            // tx_done must mark exactly the last bit, and the link must stay up throughout
            if (!slave_valid || (slave_tx_done != last_bit)) begin
               state_d     = IDLE;
               frame_err_d = 1'b1;
            end else if (last_bit) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Ready is judged against storage as it will look after this edge's push/pop
      master_ready_d = (state_d == IDLE) && rx_req && space_d;
      rx_busy_d      = (state_d == RECV);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         bit_cnt_q      <= '0;
         shift_q        <= '0;
         master_ready_q <= 1'b0;
         rx_busy_q      <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         bit_cnt_q      <= bit_cnt_d;
         shift_q        <= shift_d;
         master_ready_q <= master_ready_d;
         rx_busy_q      <= rx_busy_d;
         frame_err_q    <= frame_err_d;
      end
   end

   assign master_ready = master_ready_q;
   assign rx_busy      = rx_busy_q;
   assign frame_err    = frame_err_q;

`ifdef MASTER_IN_FIFO_EN
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]        count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      space_d  = (count_d < (PTR_W+1)'(FIFO_DEPTH));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= shift_q;
   end

   assign rx_valid = (count_q != '0);
   assign rx_data  = rx_valid ? mem_q[rd_ptr_q] : '0;
`else
   logic [DATA_WIDTH-1:0] hold_q, hold_d;
   logic                  valid_q, valid_d;

   always_comb begin
      hold_d  = hold_q;
      valid_d = valid_q;
      if (pop) valid_d = 1'b0;
      if (push) begin
         hold_d  = shift_q;
         valid_d = 1'b1;
      end
      space_d = !valid_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         hold_q  <= hold_d;
         valid_q <= valid_d;
      end
   end

   assign rx_valid = valid_q;
   assign rx_data  = hold_q;
`endif

endmodule

// File: tb/tb_master_in_port.sv
// Directed + randomized bench for master_in_port; a word queue models the output storage.
// Builds for both storage configurations (MASTER_IN_FIFO_EN selects the FIFO variant).
module tb_master_in_port;

   localparam int W = 8;
`ifdef MASTER_IN_FIFO_EN
   localparam int CAP = 4;
`else
   localparam int CAP = 1;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         rx_req = 1'b0;
   logic         slave_ready = 1'b0;
   logic         slave_valid = 1'b1;
   logic         rx_bit = 1'b0;
   logic         slave_tx_done = 1'b0;
   logic         master_ready;
   logic [W-1:0] rx_data;
   logic         rx_valid;
   logic         rx_ack = 1'b0;
   logic         rx_busy;
   logic         frame_err;

   int           vectors = 0;
   int           miscompares = 0;
   logic [W-1:0] exp_q[$];
   bit           pend = 1'b0;
   logic [W-1:0] pend_w = '0;
   bit           rand_ack = 1'b0;
   bit           ack_at_done = 1'b0;

   always #5 clk = ~clk;

   master_in_port #(.DATA_WIDTH(W), .FIFO_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .rx_req(rx_req), .slave_ready(slave_ready),
      .slave_valid(slave_valid), .rx_bit(rx_bit), .slave_tx_done(slave_tx_done),
      .master_ready(master_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ack(rx_ack), .rx_busy(rx_busy), .frame_err(frame_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: apply the model's pop/push for this edge, then compare storage outputs.
   task automatic step();
      bit do_pop;
      do_pop = (rx_ack === 1'b1) && (exp_q.size() > 0);
      @(posedge clk);
      if (do_pop) void'(exp_q.pop_front());
      if (pend) begin
         exp_q.push_back(pend_w);
         pend = 1'b0;
      end
      #1;
      chk("rx_valid", rx_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) chk("rx_data", rx_data, exp_q[0]);
      if (rand_ack) rx_ack = 1'($urandom_range(0, 1));
   endtask

   // kind: 0 good, 1 early tx_done at pos, 2 missing tx_done, 3 link drop at pos, 4 reset at pos
   task automatic frame(input logic [W-1:0] w, input int kind, input int pos);
      int t;
      bit err;
      rx_req = 1'b1;
      slave_ready = 1'b1;
      slave_valid = 1'b1;
      t = 0;
      while (master_ready !== 1'b1 && t < 60) begin
         step();
         t++;
      end
      if (t >= 60) begin
         chk("ready_timeout", 32'(master_ready), 32'd1);
         rx_req = 1'b0;
         slave_ready = 1'b0;
         return;
      end
      chk("ready_has_space", 32'(master_ready), 32'(exp_q.size() < CAP));
      step();
      rx_req = 1'b0;
      slave_ready = 1'b0;
      chk("busy_start", rx_busy, 1);
      chk("ready_drop", master_ready, 0);
      for (int k = 0; k < W; k++) begin
         rx_bit = w[k];
         slave_tx_done = (kind == 0 && k == W-1) || (kind == 1 && k == pos);
         slave_valid = !(kind == 3 && k == pos);
         err = (kind == 1 && k == pos) || (kind == 2 && k == W-1) || (kind == 3 && k == pos);
         if (kind == 4 && k == pos) begin
            #1 reset = 1'b1;
            #1;
            chk("rst_ready", master_ready, 0);
            chk("rst_valid", rx_valid, 0);
            chk("rst_data", rx_data, 0);
            chk("rst_busy", rx_busy, 0);
            chk("rst_err", frame_err, 0);
            exp_q.delete();
            pend = 1'b0;
            @(posedge clk);
            #1 reset = 1'b0;
            slave_tx_done = 1'b0;
            return;
         end
         step();
         if (err) begin
            chk("err_pulse", frame_err, 1);
            chk("err_busy", rx_busy, 0);
            slave_valid = 1'b1;
            slave_tx_done = 1'b0;
            step();
            chk("err_single", frame_err, 0);
            return;
         end
         chk("no_err", frame_err, 0);
         chk("busy", rx_busy, (k < W-1) ? 1 : 0);
      end
      slave_tx_done = 1'b0;
      pend = 1'b1;
      pend_w = w;
      if (ack_at_done) rx_ack = 1'b1;
      step();
      if (ack_at_done) rx_ack = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      chk("reset_valid", rx_valid, 0);
      chk("reset_ready", master_ready, 0);
      chk("reset_busy", rx_busy, 0);
      chk("reset_err", frame_err, 0);
      chk("reset_data", rx_data, 0);

      // Basic word with exact latency, then ack clears valid
      frame(8'hA5, 0, 0);
      chk("t1_data", rx_data, 8'hA5);
      rx_ack = 1'b1;
      step();
      rx_ack = 1'b0;
      chk("t1_ack", rx_valid, 0);

      // Early end and link drop, then a clean frame
      frame(8'h3C, 1, 5);
      frame(8'h77, 2, 0);
      frame(8'h99, 3, 3);
      frame(8'h5A, 0, 0);
      chk("t3_data", rx_data, 8'h5A);
      rx_ack = 1'b1;
      step();
      rx_ack = 1'b0;

`ifndef MASTER_IN_FIFO_EN
      // Holding register full blocks further requests until acked
      frame(8'h11, 0, 0);
      rx_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t4_blocked", master_ready, 0);
      end
      rx_ack = 1'b1;
      step();
      rx_ack = 1'b0;
      frame(8'h22, 0, 0);
      chk("t4_data", rx_data, 8'h22);
      rx_ack = 1'b1;
      step();
      rx_ack = 1'b0;
`else
      // Fill the FIFO, check blocking, then overlap a pop with the 5th frame's write
      for (int i = 1; i <= 4; i++) frame(W'(i), 0, 0);
      rx_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t5_blocked", master_ready, 0);
      end
      rx_req = 1'b0;
      rx_ack = 1'b1;
      step();
      rx_ack = 1'b0;
      ack_at_done = 1'b1;
      frame(8'h05, 0, 0);
      ack_at_done = 1'b0;
      chk("t5_count", 32'(exp_q.size()), 32'd3);
      rx_ack = 1'b1;
      for (int i = 0; i < 4; i++) step();
      rx_ack = 1'b0;
`endif

      // Reset in mid-frame, then a full-ones word
      frame(8'h6B, 4, 4);
      step();
      frame(8'hFF, 0, 0);
      chk("t6_data", rx_data, 8'hFF);
      rx_ack = 1'b1;
      step();
      rx_ack = 1'b0;

      // Randomized frames with random faults and random acknowledge
      rand_ack = 1'b1;
      for (int n = 0; n < 40; n++) begin
         int kind;
         int r;
         r = int'($urandom_range(0, 9));
         kind = (r < 6) ? 0 : r - 5;
         if (kind == 4) kind = 0;
         frame(W'($urandom), kind, (kind == 1) ? int'($urandom_range(0, W-2)) : int'($urandom_range(0, W-1)));
      end
      rand_ack = 1'b0;
      rx_ack = 1'b1;
      for (int i = 0; i < CAP + 2; i++) step();
      rx_ack = 1'b0;
      chk("drain_empty", rx_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
